// File: rtl/comparator_2bit_sync.sv
// comparator_2bit_sync
// Registered unsigned magnitude comparator for two WIDTH-bit operands.
// The compare result is a gate-level MSB-first cascade. The flags are
// registered one clock after an accepted input. They hold their value
// while in_valid is low.
module comparator_2bit_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             A_eq_B,
  output logic             A_gt_B,
  output logic             A_lt_B
);

  // Per-bit equal / greater / less terms.
  logic [WIDTH-1:0] bit_eq_s;
  logic [WIDTH-1:0] bit_gt_s;
  logic [WIDTH-1:0] bit_lt_s;

  // Cascade results.
  logic eq_s;
  logic gt_s;
  logic lt_s;

  // Registered state and its next-state values.
  logic valid_q, valid_d;
  logic eq_q, eq_d;
  logic gt_q, gt_d;
  logic lt_q, lt_d;

  // Per-bit compare terms, evaluated independently for every bit position.
  always_comb begin
    bit_eq_s = ~(A ^ B);
    bit_gt_s = A & ~B;
    bit_lt_s = ~A & B;
  end

  // MSB-first cascade.
  // The running eq_s is the AND of e_j over all bits above bit i.
  // That value gates g_i and l_i, so only the highest differing bit decides.
  always_comb begin
    eq_s = 1'b1;
    gt_s = 1'b0;
    lt_s = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      gt_s = gt_s | (eq_s & bit_gt_s[i]);
      lt_s = lt_s | (eq_s & bit_lt_s[i]);
      eq_s = eq_s & bit_eq_s[i];
    end
  end

  // Next state: load a fresh result on an accepted input, otherwise hold.
  // Because the mux selects the held flags when in_valid is low, unknown
  // operands in an idle cycle cannot reach the flag registers.
  always_comb begin
    valid_d = in_valid;
    if (in_valid) begin
      eq_d = eq_s;
      gt_d = gt_s;
      lt_d = lt_s;
    end else begin
      eq_d = eq_q;
      gt_d = gt_q;
      lt_d = lt_q;
    end
  end

  // Output registers with a synchronous reset that takes priority over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign out_valid = valid_q;
  assign A_eq_B    = eq_q;
  assign A_gt_B    = gt_q;
  assign A_lt_B    = lt_q;

endmodule

// File: tb/tb_comparator_2bit_sync.sv
// Testbench for comparator_2bit_sync.
// Each driven cycle pushes the expected flags to a scoreboard queue.
// After the next rising edge, the bench pops that entry and compares it
// with the registered outputs.
module tb_comparator_2bit_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] A;
  logic [1:0] B;
  logic       out_valid;
  logic       A_eq_B;
  logic       A_gt_B;
  logic       A_lt_B;

  int errors = 0;
  int checks = 0;

  // Scoreboard of expected {eq, gt, lt} values.
  logic [2:0] exp_q[$];

  // Model of the flags currently held by the DUT.
  logic [2:0] held_m = 3'b000;

  comparator_2bit_sync #(.WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .A_eq_B    (A_eq_B),
    .A_gt_B    (A_gt_B),
    .A_lt_B    (A_lt_B)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive one cycle, then compare the outputs #1 after the rising edge.
  task automatic step(input string tag, input bit r, input bit v,
                      input logic [1:0] a, input logic [1:0] b);
    bit exp_v;
    rst      = r;
    in_valid = v;
    A        = a;
    B        = b;
    if (v && !r) exp_q.push_back({a == b, a > b, a < b});
    @(posedge clk);
    #1;
    exp_v = v && !r;
    if (r) begin
      held_m = 3'b000;
      exp_q.delete();
    end else if (exp_v) begin
      held_m = exp_q.pop_front();
    end
    check_val(tag, {out_valid, A_eq_B, A_gt_B, A_lt_B}, {exp_v, held_m});
    if (exp_v)
      check_val({tag, "_onehot"}, {3'b000, ($countones({A_eq_B, A_gt_B, A_lt_B}) == 1)}, 4'b0001);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = 2'b00;
    B        = 2'b00;

    // Reset with a valid input present: the input must be discarded.
    step("reset0", 1'b1, 1'b1, 2'b01, 2'b00);
    step("reset1", 1'b1, 1'b1, 2'b01, 2'b00);

    // Equal operands, driven back-to-back.
    step("eq_00", 1'b0, 1'b1, 2'b00, 2'b00);
    step("eq_10", 1'b0, 1'b1, 2'b10, 2'b10);
    step("eq_11", 1'b0, 1'b1, 2'b11, 2'b11);

    // A less than B.
    step("lt_00_01", 1'b0, 1'b1, 2'b00, 2'b01);
    step("lt_10_11", 1'b0, 1'b1, 2'b10, 2'b11);

    // A greater than B, including a case where the MSB decides the result.
    step("gt_01_00", 1'b0, 1'b1, 2'b01, 2'b00);
    step("gt_11_10", 1'b0, 1'b1, 2'b11, 2'b10);
    step("gt_msb",   1'b0, 1'b1, 2'b10, 2'b01);

    // Hold: accept one input, then drop in_valid and change the operands.
    step("hold_load", 1'b0, 1'b1, 2'b11, 2'b10);
    step("hold_0",    1'b0, 1'b0, 2'b00, 2'b11);
    step("hold_1",    1'b0, 1'b0, 2'b01, 2'b10);

    // Exhaustive check of all 16 operand pairs, driven back-to-back.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        step($sformatf("exh_%0d_%0d", a, b), 1'b0, 1'b1, 2'(a), 2'(b));
      end
    end

    // Reset in the same cycle as a valid input discards that input.
    step("rst_discard", 1'b1, 1'b1, 2'b11, 2'b00);
    step("post_rst",    1'b0, 1'b0, 2'b00, 2'b00);
    step("after_rst",   1'b0, 1'b1, 2'b00, 2'b10);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
